fsm_steer: RTL and testbench
============================

FSM_STEER -- requirements
Module: fsm_steer

Interface
REQ-001 The block SHALL have parameter MAX_HOPS, default 4, giving the maximum number of q commands issued per request before giving up.
REQ-002 The block SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port req_valid, input, 1 bit: a request is present.
REQ-005 The block SHALL have port req_target, input, 3 bits: requested one-hot output code of the steered Moore FSM; legal codes are 3'b100 (r1), 3'b001 (r2) and 3'b010 (r3).
REQ-006 The block SHALL have port req_ready, output, 1 bit: high exactly when the block is in IDLE.
REQ-007 The block SHALL have port w_obs, input, 3 bits: the steered Moore FSM's w output.
REQ-008 The block SHALL have port q, output, 3 bits, registered: command to the steered FSM's q input.
REQ-009 The block SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-010 The block SHALL have port done, output, 1 bit, registered: one-cycle pulse on success.
REQ-011 The block SHALL have port err, output, 1 bit, registered: one-cycle pulse on failure.
REQ-012 The block SHALL have port err_code, output, 2 bits, registered: 01 illegal target, 10 illegal w_obs, 11 hop limit; holds its value until the next err.

Function
REQ-013 A request SHALL be accepted on an edge where req_valid and req_ready are both 1, and req_target SHALL be latched at that edge.
REQ-014 If the accepted target is illegal, the block SHALL pulse err with err_code 01 in the next cycle and remain in IDLE.
REQ-015 If the accepted target is legal, the block SHALL clear the hop counter and enter DRIVE.
REQ-016 The block SHALL implement the state machine IDLE -> DRIVE -> HOLD -> CHECK -> (DRIVE | IDLE).
REQ-017 In DRIVE, when w_obs equals the target, the block SHALL register done=1 and return to IDLE.
REQ-018 In DRIVE, when w_obs is illegal (any code other than 100, 001, 010), the block SHALL register err=1 with err_code 10 and return to IDLE.
REQ-019 In DRIVE, in all other cases, the block SHALL register q per REQ-020, increment the hop counter and enter HOLD.
REQ-020 The command table (current w_obs -> target: q) SHALL be: 100->001: 100; 100->010: 010; 001->010: 001; 001->100: 001 (via r3); 010->100: 001; 010->001: 100.
REQ-021 In HOLD, q SHALL be visible for exactly one cycle; the block SHALL then register q=000 and enter CHECK.
REQ-022 In CHECK, when w_obs equals the target, the block SHALL register done=1 and return to IDLE.
REQ-023 In CHECK, when w_obs is illegal, the block SHALL register err=1 with err_code 10 and return to IDLE.
REQ-024 In CHECK, on a mismatch with hop counter equal to MAX_HOPS, the block SHALL register err=1 with err_code 11 and return to IDLE.
REQ-025 In CHECK, on a mismatch with hop counter below MAX_HOPS, the block SHALL return to DRIVE.
REQ-026 The latency from the acceptance edge to the done cycle SHALL be 3*hops+1 cycles; for zero hops it SHALL be 2 cycles.
REQ-027 q SHALL be 000 in every cycle except the single cycle following DRIVE.
REQ-028 done and err SHALL never be asserted in the same cycle.
REQ-029 req_valid SHALL be ignored while busy is 1, and no requests SHALL be queued.
REQ-030 The hop counter SHALL be sized to hold MAX_HOPS without wrap-around.

Reset
REQ-031 While reset is 1 at a clock edge, the block SHALL set the state to IDLE, q=000, done=0, err=0, err_code=00 and hop counter=0, so that req_ready=1 and busy=0 in the following cycle.
REQ-032 A reset asserted mid-request SHALL abort the request with no done or err pulse, and q SHALL be 000 in the cycle after the reset edge.

Verification
REQ-033 The bench SHALL cover: w_obs=100, request 001 -> q=100 for one cycle, done in cycle 4 after acceptance, err never asserted.
REQ-034 The bench SHALL cover: w_obs=001, request 100, with the steered FSM modelled -> q=001 twice, done in cycle 7, w_obs sequence 001, 010, 100.
REQ-035 The bench SHALL cover: w_obs=010, request 010 -> q stays 000, done in cycle 2.
REQ-036 The bench SHALL cover: request 011 -> err in the next cycle with err_code 01, req_ready held at 1.
REQ-037 The bench SHALL cover: w_obs frozen at 100, request 010, MAX_HOPS=4 -> four q=010 pulses, err in cycle 13 with err_code 11.
REQ-038 The bench SHALL cover: reset asserted during HOLD -> next cycle q=000, busy=0, req_ready=1, no done or err pulse; w_obs forced to 000 during CHECK -> err with err_code 10.

Source files
------------

// File: rtl/fsm_steer.sv
// fsm_steer: steers a one-hot Moore FSM toward a requested w output by issuing q command pulses
module fsm_steer #(
    parameter int MAX_HOPS = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_valid,
    input  logic [2:0] req_target,
    output logic       req_ready,
    input  logic [2:0] w_obs,
    output logic [2:0] q,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [1:0] err_code
);
    localparam int HW = $clog2(MAX_HOPS + 1);
    typedef enum logic [1:0] {IDLE, DRIVE, HOLD, CHECK} state_t;
    state_t state_q, state_d;
    logic [2:0] tgt_q, tgt_d, q_q, q_d;
    logic [HW-1:0] hops_q, hops_d;
    logic done_q, done_d, err_q, err_d;
    logic [1:0] code_q, code_d;
    function automatic logic legal(input logic [2:0] x);
        return x == 3'b100 || x == 3'b001 || x == 3'b010;
    endfunction
    function automatic logic [2:0] cmd(input logic [2:0] w, input logic [2:0] t);
        return w == 3'b100 ? (t == 3'b001 ? 3'b100 : 3'b010) :
               w == 3'b001 ? 3'b001 : (t == 3'b100 ? 3'b001 : 3'b100);
    endfunction
    always_comb begin
        state_d = state_q;
        tgt_d   = tgt_q;
        hops_d  = hops_q;
        q_d     = 3'b000;
        done_d  = 1'b0;
        err_d   = 1'b0;
        code_d  = code_q;
        unique case (state_q)
            IDLE: if (req_valid) begin
                tgt_d = req_target;
                if (legal(req_target)) begin
                    state_d = DRIVE;
                    hops_d  = '0;
                end else begin
                    err_d  = 1'b1;
                    code_d = 2'b01;
                end
            end
            DRIVE: if (w_obs == tgt_q) begin
                done_d  = 1'b1;
                state_d = IDLE;
            end else if (!legal(w_obs)) begin
                err_d   = 1'b1;
                code_d  = 2'b10;
                state_d = IDLE;
            end else begin
                q_d     = cmd(w_obs, tgt_q);
                hops_d  = hops_q + 1'b1;
                state_d = HOLD;
            end
            HOLD: state_d = CHECK;
            CHECK: if (w_obs == tgt_q) begin
                done_d  = 1'b1;
                state_d = IDLE;
            end else if (!legal(w_obs)) begin
                err_d   = 1'b1;
                code_d  = 2'b10;
                state_d = IDLE;
            end else if (hops_q == HW'(MAX_HOPS)) begin
                err_d   = 1'b1;
                code_d  = 2'b11;
                state_d = IDLE;
            end else begin
                state_d = DRIVE;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            tgt_q   <= 3'b000;
            hops_q  <= '0;
            q_q     <= 3'b000;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            code_q  <= 2'b00;
        end else begin
            state_q <= state_d;
            tgt_q   <= tgt_d;
            hops_q  <= hops_d;
            q_q     <= q_d;
            done_q  <= done_d;
            err_q   <= err_d;
            code_q  <= code_d;
        end
    end
    assign req_ready = state_q == IDLE;
    assign busy      = state_q != IDLE;
    assign q         = q_q;
    assign done      = done_q;
    assign err       = err_q;
    assign err_code  = code_q;
endmodule

// File: tb/tb_fsm_steer.sv
// tb_fsm_steer: directed bench for fsm_steer with a model of the steered one-hot FSM
module tb_fsm_steer;
    logic clk = 1'b0, reset = 1'b1, req_valid = 1'b0;
    logic [2:0] req_target = 3'b000, w_obs = 3'b000;
    logic req_ready, busy, done, err;
    logic [2:0] q;
    logic [1:0] err_code;
    int vecs = 0, errs = 0;
    bit model_on = 1'b0;
    int dc, ec, qn, rl, both;
    logic [2:0] qv;
    logic [8:0] ws;

    fsm_steer #(.MAX_HOPS(4)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_target(req_target),
        .req_ready(req_ready), .w_obs(w_obs), .q(q), .busy(busy),
        .done(done), .err(err), .err_code(err_code)
    );

    always #5 clk = ~clk;

    function automatic logic [2:0] step_w(input logic [2:0] w, input logic [2:0] c);
        if (w == 3'b100) return c == 3'b100 ? 3'b001 : c == 3'b010 ? 3'b010 : w;
        if (w == 3'b001) return c == 3'b001 ? 3'b010 : w;
        if (w == 3'b010) return c == 3'b001 ? 3'b100 : c == 3'b100 ? 3'b001 : w;
        return w;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        logic [2:0] qp;
        qp = q;
        @(negedge clk);
        if (model_on) w_obs = step_w(w_obs, qp);
    endtask

    task automatic issue(input logic [2:0] t);
        req_valid  = 1'b1;
        req_target = t;
        cyc();
        req_valid  = 1'b0;
        req_target = 3'b111;
    endtask

    task automatic watch(input int n, input int poke);
        dc = 0; ec = 0; qn = 0; rl = 0; both = 0; qv = 3'b000;
        ws = {6'b0, w_obs};
        for (int i = 1; i <= n; i++) begin
            if (done && dc == 0) dc = i;
            if (err && ec == 0) ec = i;
            if (done && err) both++;
            if (q != 3'b000) begin qn++; qv = qv | q; end
            if (!req_ready) rl++;
            if (i == poke) begin req_valid = 1'b1; req_target = 3'b011; end
            cyc();
            req_valid = 1'b0;
            if (w_obs != ws[2:0]) ws = {ws[5:0], w_obs};
        end
    endtask

    initial begin
        @(negedge clk);
        chk("rst_ready", req_ready, 1); chk("rst_busy", busy, 0); chk("rst_q", q, 0);
        chk("rst_done", done, 0); chk("rst_err", err, 0); chk("rst_code", err_code, 0);
        @(negedge clk);
        reset = 1'b0;
        // one hop r1->r2, with a request poked while busy that must be ignored
        model_on = 1'b1; w_obs = 3'b100;
        issue(3'b001); watch(8, 2);
        chk("t1_done_cyc", dc, 4); chk("t1_err", ec, 0); chk("t1_qn", qn, 1);
        chk("t1_qv", qv, 3'b100); chk("t1_wseq", ws, 9'b000_100_001);
        // two hops r2->r3->r1
        w_obs = 3'b001;
        issue(3'b100); watch(9, 0);
        chk("t2_done_cyc", dc, 7); chk("t2_err", ec, 0); chk("t2_qn", qn, 2);
        chk("t2_qv", qv, 3'b001); chk("t2_wseq", ws, 9'b001_010_100);
        // already at target
        w_obs = 3'b010;
        issue(3'b010); watch(4, 0);
        chk("t3_done_cyc", dc, 2); chk("t3_qn", qn, 0); chk("t3_err", ec, 0);
        // illegal target
        issue(3'b011); watch(3, 0);
        chk("t4_err_cyc", ec, 1); chk("t4_code", err_code, 2'b01);
        chk("t4_ready_low", rl, 0); chk("t4_done", dc, 0);
        // frozen steered FSM exhausts hop budget
        model_on = 1'b0; w_obs = 3'b100;
        issue(3'b010); watch(15, 0);
        chk("t5_qn", qn, 4); chk("t5_qv", qv, 3'b010); chk("t5_err_cyc", ec, 13);
        chk("t5_code", err_code, 2'b11); chk("t5_done", dc, 0); chk("t5_both", both, 0);
        // illegal w_obs seen in DRIVE
        w_obs = 3'b111;
        issue(3'b001); watch(4, 0);
        chk("t6_err_cyc", ec, 2); chk("t6_code", err_code, 2'b10);
        // reset during HOLD
        w_obs = 3'b100;
        issue(3'b001); cyc();
        chk("t7_hold_q", q, 3'b100);
        reset = 1'b1; cyc(); reset = 1'b0;
        chk("t7_q", q, 0); chk("t7_busy", busy, 0); chk("t7_ready", req_ready, 1);
        chk("t7_done", done, 0); chk("t7_err", err, 0);
        watch(4, 0);
        chk("t7_no_done", dc, 0); chk("t7_no_err", ec, 0); chk("t7_qn", qn, 0);
        // w_obs forced illegal during CHECK
        issue(3'b010); cyc(); cyc();
        chk("t8_check_busy", busy, 1); chk("t8_check_q", q, 0);
        w_obs = 3'b000; cyc();
        chk("t8_err", err, 1); chk("t8_code", err_code, 2'b10); chk("t8_done", done, 0);
        cyc();
        chk("t8_err_pulse", err, 0); chk("t8_ready", req_ready, 1);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
